// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between the CPU and an external port.
// Each access is issue + response (2 cycles); the loser waits via cpu_stall or a withheld ext_ack.
module dmem_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [DATA_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESP_CPU = 2'd1;
  localparam logic [1:0] RESP_EXT = 2'd2;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_EXT = 1'b1;

  logic [1:0]        state;
  logic              lastGrant;
  logic [DATA_W-1:0] respAddr;
  logic              respWe;
  logic              inIdle;
  logic              grantCpu;
  logic              grantExt;

  // Reset gates the issue path so no strobe can leak out while reset is held.
  assign inIdle   = (state == IDLE) && !reset;
  assign grantCpu = inIdle && cpu_req && (!ext_req || (lastGrant == GRANT_EXT));
  assign grantExt = inIdle && ext_req && !grantCpu;

  assign cpu_stall = cpu_req && (state != RESP_CPU);
  assign ext_ack   = (state == RESP_EXT);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grantCpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grantExt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (state != IDLE) begin
      mem_addr  = respAddr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lastGrant <= GRANT_EXT;
      respAddr  <= '0;
      respWe    <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantCpu) begin
            state     <= RESP_CPU;
            lastGrant <= GRANT_CPU;
            respAddr  <= cpu_addr;
            respWe    <= cpu_we;
          end else if (grantExt) begin
            state     <= RESP_EXT;
            lastGrant <= GRANT_EXT;
            respAddr  <= ext_addr;
            respWe    <= ext_we;
          end
        end
        RESP_CPU: begin
          if (!respWe) cpu_rdata <= mem_rdata;
          state <= IDLE;
        end
        RESP_EXT: begin
          if (!respWe) ext_rdata <= mem_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, then randomized traffic against a slot-level model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears one cycle after the address; backdoor port for preload.
  logic [31:0] dmem [0:63] = '{default: 32'h0};
  logic        bdWe;
  logic [5:0]  bdIdx;
  logic [31:0] bdVal;
  always @(posedge clk) begin
    if (bdWe) dmem[bdIdx] <= bdVal;
    else if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reference model: one shared slot, each access holds it for an issue and a response cycle.
  logic [31:0] refMem [0:63];
  int          slotBusy, slotOwner, servedLast;   // owner/served: 1 = CPU, 2 = EXT
  logic [31:0] slotAddr, slotData;
  logic        slotWe;
  logic [31:0] expCpuRdata, expExtRdata;
  int          cpuDoneCnt, extDoneCnt;
  bit          cpuFree, extFree;

  task automatic runModel(input int cycles, input int mode);
    int pick;
    logic expWe, expStall, expAck;
    logic [31:0] expAddr, expWdata;
    for (int c = 0; c < cycles; c++) begin
      if (cpuFree) begin
        cpu_req   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        cpu_wdata = $urandom;
        cpuFree   = !cpu_req;
      end
      if (extFree) begin
        ext_req   = (mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 5);
        ext_we    = $urandom_range(0, 1) == 1;
        ext_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        ext_wdata = $urandom;
        extFree   = !ext_req;
      end
      @(negedge clk);
      expWe = 1'b0; expAddr = 32'h0; expWdata = 32'h0; expAck = 1'b0; expStall = cpu_req;
      if (slotBusy == 0) begin
        if (cpu_req && ext_req) pick = (servedLast == 2) ? 1 : 2;
        else if (cpu_req)       pick = 1;
        else if (ext_req)       pick = 2;
        else                    pick = 0;
        if (pick != 0) begin
          slotWe   = (pick == 1) ? cpu_we : ext_we;
          slotAddr = (pick == 1) ? cpu_addr : ext_addr;
          expWdata = (pick == 1) ? cpu_wdata : ext_wdata;
          expWe    = slotWe;
          expAddr  = slotAddr;
          slotData = refMem[slotAddr[7:2]];
          if (slotWe) refMem[slotAddr[7:2]] = expWdata;
          slotBusy = 1; slotOwner = pick; servedLast = pick;
        end
      end else begin
        expAddr  = slotAddr;
        expAck   = (slotOwner == 2);
        expStall = cpu_req && (slotOwner != 1);
        if (!slotWe && slotOwner == 1) expCpuRdata = slotData;
        if (!slotWe && slotOwner == 2) expExtRdata = slotData;
        slotBusy = 0;
      end
      chk("mem_we", {31'h0, mem_we}, {31'h0, expWe});
      chk("mem_addr", mem_addr, expAddr);
      chk("cpu_stall", {31'h0, cpu_stall}, {31'h0, expStall});
      chk("ext_ack", {31'h0, ext_ack}, {31'h0, expAck});
      if (expWe) chk("mem_wdata", mem_wdata, expWdata);
      if (cpu_req && !cpu_stall) cpuDoneCnt++;
      if (ext_ack) extDoneCnt++;
      if (cpu_req && !expStall) cpuFree = 1'b1;
      if (expAck) extFree = 1'b1;
      @(posedge clk); #1;
      chk("cpu_rdata", cpu_rdata, expCpuRdata);
      chk("ext_rdata", ext_rdata, expExtRdata);
    end
  endtask

  logic [31:0] dAddr [4];

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    for (int i = 0; i < 64; i++) refMem[i] = 32'h0;
    bdWe = 1'b1; bdIdx = 6'd4; bdVal = 32'hDEADBEEF;
    refMem[4] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 bdWe = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk("rst_ext_ack", {31'h0, ext_ack}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'h0, cpu_stall}, 32'h0);
    chk("idle_addr", mem_addr, 32'h0);

    // CPU load alone
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("ld_stall_issue", {31'h0, cpu_stall}, 32'h1);
    chk("ld_addr_issue", mem_addr, 32'h10);
    chk("ld_we_issue", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("ld_stall_resp", {31'h0, cpu_stall}, 32'h0);
    chk("ld_addr_resp", mem_addr, 32'h10);
    @(posedge clk); #1;
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;

    // EXT store then CPU readback
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_we_issue", {31'h0, mem_we}, 32'h1);
    chk("st_wdata", mem_wdata, 32'h12345678);
    chk("st_ack_issue", {31'h0, ext_ack}, 32'h0);
    @(negedge clk);
    chk("st_we_resp", {31'h0, mem_we}, 32'h0);
    chk("st_ack_resp", {31'h0, ext_ack}, 32'h1);
    @(posedge clk); #1;
    ext_req = 0; ext_we = 0;
    refMem[8] = 32'h12345678;
    @(negedge clk);
    chk("st_ack_after", {31'h0, ext_ack}, 32'h0);
    @(posedge clk); #1;
    cpu_req = 1; cpu_addr = 32'h20;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    chk("st_readback", cpu_rdata, 32'h12345678);
    cpu_req = 0;

    // Simultaneous requests after reset: CPU first, EXT two cycles later
    pulseReset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ext_req = 1; ext_we = 0; ext_addr = 32'h20;
    dAddr[0] = 32'h10; dAddr[1] = 32'h10; dAddr[2] = 32'h20; dAddr[3] = 32'h20;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("sim_addr", mem_addr, dAddr[cyc]);
      chk("sim_ack", {31'h0, ext_ack}, (cyc == 3) ? 32'h1 : 32'h0);
      chk("sim_stall", {31'h0, cpu_stall}, (cyc == 0) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      if (cyc == 1) begin cpu_req = 0; chk("sim_cpu_rdata", cpu_rdata, 32'hDEADBEEF); end
      if (cyc == 3) begin ext_req = 0; chk("sim_ext_rdata", ext_rdata, 32'h12345678); end
    end

    // Reset during RESP_EXT aborts the access; retry completes
    pulseReset();
    ext_req = 1; ext_we = 0; ext_addr = 32'h10;
    @(negedge clk);
    chk("abort_issue", mem_addr, 32'h10);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_ack", {31'h0, ext_ack}, 32'h0);
    chk("abort_we", {31'h0, mem_we}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_ext_rdata", ext_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("retry_ack_issue", {31'h0, ext_ack}, 32'h0);
    chk("retry_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("retry_ack", {31'h0, ext_ack}, 32'h1);
    @(posedge clk); #1;
    chk("retry_rdata", ext_rdata, 32'hDEADBEEF);

    // CPU request dropped while waiting never reaches memory
    ext_addr = 32'h20;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("drop_stall", {31'h0, cpu_stall}, 32'h1);
    @(posedge clk); #1;
    cpu_req = 0; ext_req = 0;
    @(negedge clk);
    chk("drop_we", {31'h0, mem_we}, 32'h0);
    chk("drop_addr", mem_addr, 32'h0);

    // Continuous contention, then random traffic, then EXT-only traffic
    @(posedge clk); #1;
    pulseReset();
    slotBusy = 0; slotOwner = 0; servedLast = 2;
    expCpuRdata = 32'h0; expExtRdata = 32'h0;
    cpuFree = 1'b1; extFree = 1'b1;
    cpuDoneCnt = 0; extDoneCnt = 0;
    runModel(16, 1);
    chk("rr_cpu_done", cpuDoneCnt, 32'd4);
    chk("rr_ext_done", extDoneCnt, 32'd4);
    runModel(300, 0);
    runModel(40, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
